// File: rtl/imm_gen_pipe_if.sv
// Purpose: instruction-in / immediate-out handshake bundle for imm_gen_pipe.
// Latency: none (signal container only).
// Backpressure: in_ready/out_ready carry valid-ready flow control on each side.
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [2:0]      immsrc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] immext;
  logic [2:0]      fmt;
  logic            illegal;

  // Block side: consumes instructions, produces immediates.
  modport slave (
    input  in_valid, instr, immsrc, out_ready,
    output in_ready, out_valid, immext, fmt, illegal
  );

  // Environment side: fetch drives instructions, execute consumes results.
  modport master (
    output in_valid, instr, immsrc, out_ready,
    input  in_ready, out_valid, immext, fmt, illegal
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Purpose: decode immediate format, extend to XLEN, hold result in a 2-entry skid buffer.
// Latency: 1 cycle from input acceptance to out_valid; 1 entry/cycle sustained.
// Backpressure: in_ready = !skid.valid (registered), so no out_ready->in_ready path.
module imm_gen_pipe #(
  parameter int XLEN        = 32,
  parameter bit AUTO_DECODE = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  imm_gen_pipe_if.slave bus
);

  localparam logic [2:0] F_I    = 3'b000;
  localparam logic [2:0] F_S    = 3'b001;
  localparam logic [2:0] F_B    = 3'b010;
  localparam logic [2:0] F_J    = 3'b011;
  localparam logic [2:0] F_U    = 3'b100;
  localparam logic [2:0] F_Z    = 3'b101;
  localparam logic [2:0] F_SH   = 3'b110;
  localparam logic [2:0] F_NONE = 3'b111;

  logic [31:0]     w_i;
  logic [6:0]      w_op;
  logic [2:0]      w_f3;
  logic [2:0]      w_fmt;
  logic            w_ill;
  logic            w_sh5;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic            w_in_xfer;
  logic            w_m_free;

  logic            r_m_vld;
  logic [XLEN-1:0] r_m_imm;
  logic [2:0]      r_m_fmt;
  logic            r_m_ill;
  logic            r_k_vld;
  logic [XLEN-1:0] r_k_imm;
  logic [2:0]      r_k_fmt;
  logic            r_k_ill;

  assign w_i  = bus.instr;
  assign w_op = w_i[6:0];
  assign w_f3 = w_i[14:12];

  // Select the immediate format (opcode decode or explicit control) and flag unknown encodings.
  always_comb begin
    w_fmt = F_NONE;
    w_ill = 1'b1;
    w_sh5 = (XLEN == 32);
    if (AUTO_DECODE) begin
      case (w_op)
        7'b0000011, 7'b1100111: begin w_fmt = F_I; w_ill = 1'b0; end
        7'b0010011: begin
          w_fmt = (w_f3 == 3'b001 || w_f3 == 3'b101) ? F_SH : F_I;
          w_ill = 1'b0;
        end
        7'b0011011: begin
          // Word-sized shifts only exist on RV64 and always use a 5-bit shamt.
          if (XLEN == 64) begin
            w_fmt = (w_f3 == 3'b001 || w_f3 == 3'b101) ? F_SH : F_I;
            w_ill = 1'b0;
            w_sh5 = 1'b1;
          end
        end
        7'b0100011: begin w_fmt = F_S; w_ill = 1'b0; end
        7'b1100011: begin w_fmt = F_B; w_ill = 1'b0; end
        7'b1101111: begin w_fmt = F_J; w_ill = 1'b0; end
        7'b0110111, 7'b0010111: begin w_fmt = F_U; w_ill = 1'b0; end
        7'b1110011: begin w_fmt = w_f3[2] ? F_Z : F_I; w_ill = 1'b0; end
        7'b0110011, 7'b0111011, 7'b0001111: begin w_fmt = F_NONE; w_ill = 1'b0; end
        default: begin w_fmt = F_NONE; w_ill = 1'b1; end
      endcase
    end else begin
      w_fmt = bus.immsrc;
      w_ill = (bus.immsrc == F_NONE);
    end
  end

  // Assemble the 32-bit immediate; zero-extended formats keep bit 31 clear so the final sign cast is safe.
  always_comb begin
    w_imm32 = '0;
    case (w_fmt)
      F_I:  w_imm32 = {{20{w_i[31]}}, w_i[31:20]};
      F_S:  w_imm32 = {{20{w_i[31]}}, w_i[31:25], w_i[11:7]};
      F_B:  w_imm32 = {{19{w_i[31]}}, w_i[31], w_i[7], w_i[30:25], w_i[11:8], 1'b0};
      F_J:  w_imm32 = {{11{w_i[31]}}, w_i[31], w_i[19:12], w_i[20], w_i[30:21], 1'b0};
      F_U:  w_imm32 = {w_i[31:12], 12'b0};
      F_Z:  w_imm32 = {27'b0, w_i[19:15]};
      F_SH: w_imm32 = w_sh5 ? {27'b0, w_i[24:20]} : {26'b0, w_i[25:20]};
      default: w_imm32 = '0;
    endcase
  end

  assign w_imm     = XLEN'($signed(w_imm32));
  assign w_in_xfer = bus.in_valid & ~r_k_vld;
  assign w_m_free  = ~r_m_vld | bus.out_ready;

  // Main/skid buffer: M refills from K first to preserve order; K only fills while M is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_vld <= 1'b0;
      r_m_imm <= '0;
      r_m_fmt <= F_NONE;
      r_m_ill <= 1'b0;
      r_k_vld <= 1'b0;
      r_k_imm <= '0;
      r_k_fmt <= F_NONE;
      r_k_ill <= 1'b0;
    end else if (flush) begin
      r_m_vld <= 1'b0;
      r_k_vld <= 1'b0;
    end else if (w_m_free) begin
      if (r_k_vld) begin
        r_m_vld <= 1'b1;
        r_m_imm <= r_k_imm;
        r_m_fmt <= r_k_fmt;
        r_m_ill <= r_k_ill;
        r_k_vld <= 1'b0;
      end else if (w_in_xfer) begin
        r_m_vld <= 1'b1;
        r_m_imm <= w_imm;
        r_m_fmt <= w_fmt;
        r_m_ill <= w_ill;
      end else begin
        r_m_vld <= 1'b0;
      end
    end else if (w_in_xfer) begin
      r_k_vld <= 1'b1;
      r_k_imm <= w_imm;
      r_k_fmt <= w_fmt;
      r_k_ill <= w_ill;
    end
  end

  assign bus.in_ready  = ~r_k_vld;
  assign bus.out_valid = r_m_vld;
  assign bus.immext    = r_m_imm;
  assign bus.fmt       = r_m_fmt;
  assign bus.illegal   = r_m_ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Purpose: directed checks of imm_gen_pipe decode, extension, skid buffering, flush and reset.
// Latency: expects results one cycle after acceptance.
// Backpressure: exercises out_ready stalls and the registered in_ready.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        t_flush = 1'b0;
  logic [1:0]  t_sel = 2'd0;
  logic        t_vld = 1'b0;
  logic [31:0] t_instr = 32'h0;
  logic [2:0]  t_src = 3'b0;
  logic        t_ordy = 1'b1;

  int checks = 0;
  int failures = 0;

  imm_gen_pipe_if #(.XLEN(32)) b32 ();
  imm_gen_pipe_if #(.XLEN(64)) b64 ();
  imm_gen_pipe_if #(.XLEN(32)) bx  ();

  assign b32.in_valid = t_vld && (t_sel == 2'd0);
  assign b64.in_valid = t_vld && (t_sel == 2'd1);
  assign bx.in_valid  = t_vld && (t_sel == 2'd2);
  assign b32.instr = t_instr;
  assign b64.instr = t_instr;
  assign bx.instr  = t_instr;
  assign b32.immsrc = t_src;
  assign b64.immsrc = t_src;
  assign bx.immsrc  = t_src;
  assign b32.out_ready = t_ordy;
  assign b64.out_ready = t_ordy;
  assign bx.out_ready  = t_ordy;

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b1)) u32 (.clk(clk), .rst_n(rst_n), .flush(t_flush), .bus(b32));
  imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1'b1)) u64 (.clk(clk), .rst_n(rst_n), .flush(t_flush), .bus(b64));
  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b0)) ux  (.clk(clk), .rst_n(rst_n), .flush(t_flush), .bus(bx));

  always #5 clk = ~clk;

  logic        g_vld, g_rdy, g_ill;
  logic [63:0] g_imm;
  logic [2:0]  g_fmt;

  // View of whichever instance is currently selected.
  always_comb begin
    g_vld = b32.out_valid; g_rdy = b32.in_ready; g_ill = b32.illegal;
    g_imm = {32'b0, b32.immext}; g_fmt = b32.fmt;
    case (t_sel)
      2'd1: begin
        g_vld = b64.out_valid; g_rdy = b64.in_ready; g_ill = b64.illegal;
        g_imm = b64.immext; g_fmt = b64.fmt;
      end
      2'd2: begin
        g_vld = bx.out_valid; g_rdy = bx.in_ready; g_ill = bx.illegal;
        g_imm = {32'b0, bx.immext}; g_fmt = bx.fmt;
      end
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] instr;
    logic [2:0]  src;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  localparam int NV = 19;
  vec_t vt[NV];
  logic [31:0] bp[4];
  logic        exp_rdy[8];

  initial begin
    vt[0]  = '{2'd0, 32'hFFF00093, 3'd0, 64'h00000000FFFFFFFF, 3'b000, 1'b0};
    vt[1]  = '{2'd0, 32'hFE20AE23, 3'd0, 64'h00000000FFFFFFFC, 3'b001, 1'b0};
    vt[2]  = '{2'd0, 32'h800000B7, 3'd0, 64'h0000000080000000, 3'b100, 1'b0};
    vt[3]  = '{2'd0, 32'h00000463, 3'd0, 64'h0000000000000008, 3'b010, 1'b0};
    vt[4]  = '{2'd0, 32'hFFDFF06F, 3'd0, 64'h00000000FFFFFFFC, 3'b011, 1'b0};
    vt[5]  = '{2'd1, 32'h800000B7, 3'd0, 64'hFFFFFFFF80000000, 3'b100, 1'b0};
    vt[6]  = '{2'd1, 32'h03F09093, 3'd0, 64'h000000000000003F, 3'b110, 1'b0};
    vt[7]  = '{2'd0, 32'h0000007F, 3'd0, 64'h0000000000000000, 3'b111, 1'b1};
    vt[8]  = '{2'd0, 32'h00B50533, 3'd0, 64'h0000000000000000, 3'b111, 1'b0};
    vt[9]  = '{2'd2, 32'h000FD073, 3'd5, 64'h000000000000001F, 3'b101, 1'b0};
    vt[10] = '{2'd0, 32'h000FD073, 3'd0, 64'h000000000000001F, 3'b101, 1'b0};
    vt[11] = '{2'd0, 32'h01F09093, 3'd0, 64'h000000000000001F, 3'b110, 1'b0};
    vt[12] = '{2'd1, 32'h03F0909B, 3'd0, 64'h000000000000001F, 3'b110, 1'b0};
    vt[13] = '{2'd0, 32'h03F0909B, 3'd0, 64'h0000000000000000, 3'b111, 1'b1};
    vt[14] = '{2'd2, 32'h12345678, 3'd7, 64'h0000000000000000, 3'b111, 1'b1};
    vt[15] = '{2'd2, 32'hFFF00093, 3'd0, 64'h00000000FFFFFFFF, 3'b000, 1'b0};
    vt[16] = '{2'd0, 32'h00001097, 3'd0, 64'h0000000000001000, 3'b100, 1'b0};
    vt[17] = '{2'd1, 32'hFFF00093, 3'd0, 64'hFFFFFFFFFFFFFFFF, 3'b000, 1'b0};
    vt[18] = '{2'd0, 32'h40105093, 3'd0, 64'h0000000000000001, 3'b110, 1'b0};
    bp[0] = 32'h00100093; bp[1] = 32'h00200093; bp[2] = 32'h00300093; bp[3] = 32'h00400093;
    exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    // Asynchronous reset assertion, checked before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst32_out_valid", 64'(b32.out_valid), 64'd0);
    chk("rst32_in_ready",  64'(b32.in_ready),  64'd1);
    chk("rst32_fmt",       64'(b32.fmt),       64'd7);
    chk("rst32_illegal",   64'(b32.illegal),   64'd0);
    chk("rst32_immext",    64'(b32.immext),    64'd0);
    chk("rst64_immext",    b64.immext,         64'd0);
    chk("rstx_fmt",        64'(bx.fmt),        64'd7);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven decode: offer one entry, expect it exactly one cycle later.
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      t_sel = vt[i].sel; t_instr = vt[i].instr; t_src = vt[i].src; t_vld = 1'b1; t_ordy = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), 64'(g_rdy), 64'd1);
      chk($sformatf("vec%0d_pre_valid", i), 64'(g_vld), 64'd0);
      @(posedge clk); #1;
      t_vld = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 64'(g_vld), 64'd1);
      chk($sformatf("vec%0d_immext", i), g_imm, vt[i].imm);
      chk($sformatf("vec%0d_fmt", i), 64'(g_fmt), 64'(vt[i].fmt));
      chk($sformatf("vec%0d_illegal", i), 64'(g_ill), 64'(vt[i].ill));
    end

    // Backpressure: out_ready low for cycles 2-4 while four entries are offered back to back.
    begin
      int idx = 0;
      int nout = 0;
      logic held = 1'b0;
      logic [63:0] prev_imm = '0;
      @(posedge clk); #1;
      t_vld = 1'b0; t_sel = 2'd0;
      for (int cyc = 0; cyc < 10; cyc++) begin
        if (cyc > 0) begin @(posedge clk); #1; end
        t_ordy  = !(cyc >= 1 && cyc <= 3);
        t_vld   = (idx < 4);
        t_instr = bp[(idx < 4) ? idx : 3];
        @(negedge clk);
        if (cyc < 8) chk($sformatf("bp_in_ready_c%0d", cyc), 64'(g_rdy), 64'(exp_rdy[cyc]));
        if (held) chk($sformatf("bp_stable_c%0d", cyc), g_imm, prev_imm);
        if (g_vld && t_ordy) begin
          chk($sformatf("bp_order_%0d", nout), g_imm, 64'(nout + 1));
          nout++;
        end
        held = g_vld && !t_ordy;
        prev_imm = g_imm;
        if (t_vld && g_rdy) idx++;
      end
      chk("bp_count", 64'(nout), 64'd4);
      t_vld = 1'b0;
    end

    // Flush with M and K full and an input offered.
    @(posedge clk); #1;
    t_ordy = 1'b0; t_vld = 1'b1; t_instr = bp[0];
    @(posedge clk); #1; t_instr = bp[1];
    @(posedge clk); #1; t_instr = bp[2]; t_flush = 1'b1;
    @(negedge clk);
    chk("fl1_full_in_ready", 64'(g_rdy), 64'd0);
    @(posedge clk); #1; t_flush = 1'b0; t_vld = 1'b0;
    @(negedge clk);
    chk("fl1_out_valid", 64'(g_vld), 64'd0);
    chk("fl1_in_ready", 64'(g_rdy), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("fl1_dropped", 64'(g_vld), 64'd0);

    // Flush with only M full, so in_ready is high while flush and in_valid coincide.
    @(posedge clk); #1; t_vld = 1'b1; t_instr = bp[0];
    @(posedge clk); #1; t_instr = bp[3]; t_flush = 1'b1;
    @(negedge clk);
    chk("fl2_in_ready", 64'(g_rdy), 64'd1);
    @(posedge clk); #1; t_flush = 1'b0; t_vld = 1'b0;
    @(negedge clk);
    chk("fl2_out_valid", 64'(g_vld), 64'd0);

    // Reset pulse mid-cycle with M and K full.
    @(posedge clk); #1; t_vld = 1'b1; t_instr = bp[0];
    @(posedge clk); #1; t_instr = bp[1];
    @(posedge clk); #1; t_vld = 1'b0;
    @(negedge clk);
    chk("rs_pre_full", 64'(g_rdy), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_out_valid", 64'(g_vld), 64'd0);
    chk("rs_immext", g_imm, 64'd0);
    chk("rs_fmt", 64'(g_fmt), 64'd7);
    chk("rs_illegal", 64'(g_ill), 64'd0);
    chk("rs_in_ready", 64'(g_rdy), 64'd1);
    @(negedge clk); rst_n = 1'b1;
    t_ordy = 1'b1;
    repeat (2) @(negedge clk);
    chk("rs_k_cleared", 64'(g_vld), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, parametrised immediate generator for the decode stage. Covers every RV32I/RV64I immediate format, including U, CSR zimm and shift-amount. It decodes the format from the opcode or takes it from control, sign- or zero-extends to XLEN, and presents the result behind a 2-entry valid/ready skid buffer. It sits between instruction fetch and the register-read/execute boundary, replacing the combinational extender.

## Interface
- XLEN, 32, datapath width; legal values are 32 or 64.
- AUTO_DECODE, 1, format source: 1 = derived from instr opcode/funct3; 0 = taken from immsrc.

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous; discards all buffered entries
- in_valid  input  1  instr/immsrc valid
- in_ready  output  1  block can accept this cycle
- instr  input  32  raw instruction word
- immsrc  input  3  explicit format; ignored when AUTO_DECODE=1
- out_valid  output  1  immext/fmt/illegal valid
- out_ready  input  1  consumer accepts this cycle
- immext  output  XLEN  extended immediate
- fmt  output  3  format actually applied
- illegal  output  1  no recognised format

## Operation
- Format codes:
  - 000 I: sext instr[31:20]
  - 001 S: sext {instr[31:25], instr[11:7]}
  - 010 B: sext {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - 011 J: sext {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - 100 U: sext {instr[31:12], 12'b0}. Sign-extended from bit 31 when XLEN=64.
  - 101 Z: zext instr[19:15]
  - 110 SH: zext instr[25:20] when XLEN=64; zext instr[24:20] when XLEN=32
  - 111 NONE: immext = 0
- Auto decode, on instr[6:0]:
  - 0000011 load: I
  - 1100111 JALR: I
  - 0010011 OP-IMM: SH if funct3 is 001 or 101, else I
  - 0011011 OP-IMM-32 (XLEN=64 only): same rule as OP-IMM, with SH width fixed to instr[24:20]
  - 0100011: S
  - 1100011: B
  - 1101111: J
  - 0110111, 0010111: U
  - 1110011 SYSTEM: Z if funct3[2]=1, else I
  - 0110011 OP, 0111011 OP-32, 0001111 FENCE: NONE with illegal=0
  - any other opcode: NONE with illegal=1
- Explicit mode: fmt = immsrc; illegal=1 only when immsrc=111.
- Buffer: main output register M and skid register K, each holding {immext, fmt, illegal, valid}.
  - Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
  - in_ready = !K.valid, driven from a register only. There is no combinational path from out_ready to in_ready.
  - Input accepted while M is empty or draining: the entry goes to M.
  - Input accepted while M is held (out_valid & !out_ready): the entry goes to K.
  - On an M drain with K valid: K moves to M and K is cleared.
  - Order is strictly FIFO. No entry is lost or duplicated.
- M contents are stable while out_valid & !out_ready.
- flush: M.valid and K.valid are cleared at the next edge. An input offered in the same cycle is dropped. flush wins over every simultaneous transfer.

## Timing
- Latency is 1 cycle: an entry accepted at edge n is on the outputs after edge n; out_valid is high in cycle n+1.
- Throughput is 1 entry/cycle while out_ready=1.
- Backpressure: after one entry lands in K, in_ready falls the following cycle. It rises one cycle after K drains.
- Reset (rst_n low, asynchronous, any cycle including mid-transfer):
  - out_valid=0, immext=0, fmt=111, illegal=0
  - in_ready=1
  - K cleared
- Outputs are registered. There is no combinational input-to-output path.

## Test plan
- I/S/U decode, AUTO_DECODE=1, XLEN=32, out_ready=1:
  - 0xFFF00093 -> immext 0xFFFFFFFF, fmt 000
  - 0xFE20AE23 -> 0xFFFFFFFC, fmt 001
  - 0x800000B7 -> 0x80000000, fmt 100
  - each result appears exactly 1 cycle after acceptance
- B/J decode:
  - 0x00000463 -> 0x00000008, fmt 010
  - 0xFFDFF06F -> 0xFFFFFFFC, fmt 011
- XLEN=64:
  - 0x800000B7 -> 0xFFFFFFFF80000000
  - 0x03F09093 (slli x1,x1,63) -> 0x000000000000003F, fmt 110
- Illegal and explicit modes:
  - 0x0000007F -> illegal 1, immext 0, fmt 111
  - 0x00B50533 (add) -> illegal 0, fmt 111
  - AUTO_DECODE=0, immsrc=101, instr 0x000FD073 -> immext 0x1F, fmt 101
- Backpressure: in_valid held high with 4 distinct instrs, out_ready low for cycles 2-4.
  - in_ready drops after 2 entries are buffered.
  - M stays stable throughout the stall.
  - All 4 results emerge in order, with none lost or duplicated.
- Flush and reset: with M and K both full, assert flush together with in_valid.
  - Next cycle: out_valid 0, in_ready 1; the new input is dropped.
  - Repeat with rst_n pulsed low mid-transfer: outputs reach their reset values immediately, without waiting for a clock edge.
